// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory controller.
// Used by the controller top and its lane-alignment helper.
package dmem_pkg;
   localparam int DMEM_DEPTH_WORDS = 32;

   typedef enum logic [1:0] {
      SIZE_B = 2'b00,
      SIZE_H = 2'b01,
      SIZE_W = 2'b10
   } mem_size_e;

   typedef enum logic {
      IDLE   = 1'b0,
      RMW_WR = 1'b1
   } dmem_state_e;
endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane logic: load extract/extend and sub-word store merge.
// Size 11 is treated like a word here; the controller never lets it reach memory.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [31:0] word_in,
   input  logic [1:0]  addr_lo,
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   input  logic [31:0] wdata,
   output logic [31:0] load_out,
   output logic [31:0] merged_word
);
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [3:0]  lane_en;

   always_comb begin
      case (addr_lo)
         2'd0:    byte_sel = word_in[7:0];
         2'd1:    byte_sel = word_in[15:8];
         2'd2:    byte_sel = word_in[23:16];
         default: byte_sel = word_in[31:24];
      endcase
      half_sel = addr_lo[1] ? word_in[31:16] : word_in[15:0];

      load_out = word_in;
      if (size == SIZE_B) begin
         load_out = {{24{byte_sel[7] & ~is_unsigned}}, byte_sel};
      end else if (size == SIZE_H) begin
         load_out = {{16{half_sel[15] & ~is_unsigned}}, half_sel};
      end

      case (size)
         SIZE_B:  lane_en = 4'b0001 << addr_lo;
         SIZE_H:  lane_en = addr_lo[1] ? 4'b1100 : 4'b0011;
         default: lane_en = 4'b1111;
      endcase
   end

   // Byte stores replicate wdata[7:0]; halfword stores replicate wdata[15:0].
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] src_byte;
         assign src_byte = (size == SIZE_B) ? wdata[7:0] :
                           (size == SIZE_H) ? wdata[8*(gi%2) +: 8] :
                                              wdata[8*gi +: 8];
         assign merged_word[8*gi +: 8] = lane_en[gi] ? src_byte : word_in[8*gi +: 8];
      end
   endgenerate
endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: arbitrates core and external ports onto one word
// memory, performs sub-word stores as read-modify-write and aligns loads.
module dmem_ctrl
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = DMEM_DEPTH_WORDS
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        core_req_i,
   input  logic        core_we_i,
   input  logic [31:0] core_addr_i,
   input  logic [1:0]  core_size_i,
   input  logic        core_unsigned_i,
   input  logic [31:0] core_wdata_i,
   output logic        core_stall_o,
   output logic [31:0] core_rdata_o,
   output logic        core_err_o,
   input  logic        ext_req_i,
   input  logic        ext_we_i,
   input  logic [31:0] ext_addr_i,
   input  logic [31:0] ext_wdata_i,
   output logic        ext_gnt_o,
   output logic [31:0] ext_rdata_o,
   output logic [31:0] mem_addr_o,
   output logic        mem_wr_en_o,
   output logic [31:0] mem_wdata_o,
   input  logic [31:0] mem_rdata_i
);
   localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH_WORDS * 4);

   dmem_state_e state_q, state_next;
   logic [31:0] rmw_word_q, rmw_addr_q;
   logic        last_gnt_q;

   logic        core_err, core_ok, core_sub_store, grant_core, grant_ext;
   logic [31:0] align_word, load_data, merged_data;
   logic        unused_ext_lo;

   assign unused_ext_lo = ^ext_addr_i[1:0];
   assign align_word    = (state_q == RMW_WR) ? rmw_word_q : mem_rdata_i;

   dmem_lane_align u_align (
      .word_in     (align_word),
      .addr_lo     (core_addr_i[1:0]),
      .size        (core_size_i),
      .is_unsigned (core_unsigned_i),
      .wdata       (core_wdata_i),
      .load_out    (load_data),
      .merged_word (merged_data)
   );

   always_comb begin
      core_err = core_req_i & ((core_size_i == 2'b11) |
                               ((core_size_i == SIZE_H) & core_addr_i[0]) |
                               ((core_size_i == SIZE_W) & (|core_addr_i[1:0])) |
                               (core_addr_i >= ADDR_LIMIT));
      core_ok        = core_req_i & ~core_err;
      core_sub_store = core_we_i & (core_size_i != SIZE_W);
      // Round-robin on contention: the side that was not granted last wins.
      grant_core = ~reset & (state_q == IDLE) & core_ok & (~ext_req_i | last_gnt_q);
      grant_ext  = ~reset & (state_q == IDLE) & ext_req_i & (~core_ok | ~last_gnt_q);

      state_next   = state_q;
      core_stall_o = 1'b0;
      core_rdata_o = '0;
      core_err_o   = core_err;
      ext_gnt_o    = 1'b0;
      ext_rdata_o  = '0;
      mem_addr_o   = {core_addr_i[31:2], 2'b00};
      mem_wr_en_o  = 1'b0;
      mem_wdata_o  = core_wdata_i;

      case (state_q)
         IDLE: begin
            if (grant_ext) begin
               mem_addr_o  = {ext_addr_i[31:2], 2'b00};
               mem_wr_en_o = ext_we_i;
               mem_wdata_o = ext_wdata_i;
               ext_gnt_o   = 1'b1;
               ext_rdata_o = mem_rdata_i;
               core_stall_o = core_ok;
            end else if (grant_core) begin
               if (core_sub_store) begin
                  core_stall_o = 1'b1;
                  state_next   = RMW_WR;
               end else if (core_we_i) begin
                  mem_wr_en_o = 1'b1;
               end else begin
                  core_rdata_o = load_data;
               end
            end
         end
         RMW_WR: begin
            mem_addr_o  = rmw_addr_q;
            mem_wr_en_o = 1'b1;
            mem_wdata_o = merged_data;
            state_next  = IDLE;
         end
         default: state_next = IDLE;
      endcase

      if (reset) begin
         state_next   = IDLE;
         core_stall_o = 1'b0;
         core_rdata_o = '0;
         core_err_o   = 1'b0;
         ext_gnt_o    = 1'b0;
         ext_rdata_o  = '0;
         mem_wr_en_o  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         rmw_word_q <= '0;
         rmw_addr_q <= '0;
         last_gnt_q <= 1'b1;
      end else begin
         state_q <= state_next;
         if (grant_core && core_we_i && core_sub_store) begin
            rmw_word_q <= mem_rdata_i;
            rmw_addr_q <= {core_addr_i[31:2], 2'b00};
         end
         if (grant_core) begin
            last_gnt_q <= 1'b0;
         end else if (grant_ext) begin
            last_gnt_q <= 1'b1;
         end
      end
   end
endmodule
